// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter for the single register_file write port.
// Each producer has a small FIFO; a round-robin pick issues one registered write per cycle.
module regfile_write_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                    cclk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [ADDR_W-1:0]       req0_reg,
    input  logic [DATA_W-1:0]       req0_data,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [ADDR_W-1:0]       req1_reg,
    input  logic [DATA_W-1:0]       req1_data,
    output logic                    write,
    output logic [ADDR_W-1:0]       write_reg,
    output logic [DATA_W-1:0]       write_data,
    output logic [(1<<ADDR_W)-1:0]  pending
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [1:0][DEPTH-1:0][ADDR_W-1:0] rmem_q, rmem_d;
    logic [1:0][DEPTH-1:0][DATA_W-1:0] dmem_q, dmem_d;
    logic [1:0][DEPTH-1:0]             vld_q, vld_d;
    logic [1:0][PTR_W-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0][CNT_W-1:0]             cnt_q, cnt_d;
    logic                              last_grant_q, last_grant_d;
    logic                              write_q, write_d;
    logic [ADDR_W-1:0]                 write_reg_q, write_reg_d;
    logic [DATA_W-1:0]                 write_data_q, write_data_d;

    logic [1:0]                        in_valid, ready, push, nonempty, pop;
    logic [1:0][ADDR_W-1:0]            in_reg;
    logic [1:0][DATA_W-1:0]            in_data;
    logic                              sel, any;
    logic [ADDR_W-1:0]                 head_reg;
    logic [DATA_W-1:0]                 head_data;

    assign in_valid = {req1_valid, req0_valid};
    assign in_reg   = {req1_reg, req0_reg};
    assign in_data  = {req1_data, req0_data};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ready[p]    = !rst && (cnt_q[p] < CNT_W'(DEPTH));
            push[p]     = in_valid[p] && ready[p];
            nonempty[p] = (cnt_q[p] != '0);
        end
        any = |nonempty;
        // Round-robin only matters under contention; a lone requester always wins.
        if (&nonempty) sel = ~last_grant_q;
        else           sel = nonempty[1];
        pop          = '0;
        pop[sel]     = any;
        last_grant_d = (&nonempty) ? sel : last_grant_q;
        head_reg     = rmem_q[sel][rptr_q[sel]];
        head_data    = dmem_q[sel][rptr_q[sel]];
    end

    always_comb begin
        rmem_d = rmem_q;
        dmem_d = dmem_q;
        vld_d  = vld_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                rmem_d[p][wptr_q[p]] = in_reg[p];
                dmem_d[p][wptr_q[p]] = in_data[p];
                vld_d[p][wptr_q[p]]  = 1'b1;
                wptr_d[p]            = wptr_q[p] + PTR_W'(1);
            end
            if (pop[p]) begin
                vld_d[p][rptr_q[p]] = 1'b0;
                rptr_d[p]           = rptr_q[p] + PTR_W'(1);
            end
            cnt_d[p] = cnt_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
        end
    end

    // Writes to reg 0 consume their slot but never reach the register file.
    always_comb begin
        write_d      = any && (head_reg != '0);
        write_reg_d  = write_d ? head_reg  : write_reg_q;
        write_data_d = write_d ? head_data : write_data_q;
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            rmem_q       <= '0;
            dmem_q       <= '0;
            vld_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            rmem_q       <= rmem_d;
            dmem_q       <= dmem_d;
            vld_q        <= vld_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int p = 0; p < 2; p++)
            for (int e = 0; e < DEPTH; e++)
                if (vld_q[p][e]) pending[rmem_q[p][e]] = 1'b1;
        if (write_q) pending[write_reg_q] = 1'b1;
        pending[0] = 1'b0;
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign write      = write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

endmodule
